// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-interface types: word type, RAM handshake state,
// bus controller FSM state and the latched grant record.
package cpu_types_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // RAM side handshake as reported by the memory model
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  // Bus controller FSM; prefixed so the names do not collide with ramstate_t
  typedef enum logic [1:0] {BC_IDLE, BC_BUSY, BC_DONE} busctl_state_t;

  // Who owns the RAM for the current word
  typedef struct packed {
    logic cpu;
    logic is_data;
    logic is_write;
  } busgrant_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at ptr; on advance the
// pointer moves one past the current winner so that requester is served last next time.
module rr_arbiter
#(
  parameter int N = 2
)
(
  input  logic         CLK,
  input  logic         nRST,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt,
  output logic         valid
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] widx;
  logic [PW-1:0] k;
  logic          found;

  assign valid = |req;

  // first requester at or after ptr, wrapping
  always_comb begin
    gnt   = '0;
    widx  = '0;
    k     = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = PW'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        widx   = k;
      end
    end
  end

  generate
    if (N > 1) begin : g_rr
      // pointer moves past the winner when told the winner's word is done
      always_ff @(posedge CLK) begin
        if (!nRST)
          ptr <= '0;
        else if (advance && valid)
          ptr <= (int'(widx) == N-1) ? '0 : widx + 1'b1;
      end
    end else begin : g_fixed
      assign ptr = '0;
    end
  endgenerate
endmodule

// File: rtl/bus_controller.sv
// Cache<->RAM bus controller: arbitrates icache/dcache requests from all cores,
// runs one word at a time on the single-ported RAM and keeps dcache 2-word
// bursts atomic per core via a lock taken after the first data word.
module bus_controller
  import cpu_types_pkg::*;
#(
  parameter int    CPUS     = 2,
  parameter int    TIMEOUT  = 255,
  parameter word_t ERR_DATA = 32'hBAD1BAD1
)
(
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] iload,
  output logic [CPUS-1:0][31:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  ramstate_t             ramstate,
  output logic                  err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  busctl_state_t   state;
  busgrant_t       grant;
  busgrant_t       sel;
  logic            sel_vld;
  logic [31:0]     sel_addr;
  word_t           load_q;
  logic [TW-1:0]   timer;
  logic            lock;
  logic            burst_cnt;

  logic [CPUS-1:0] dreq;
  logic [CPUS-1:0] done_oh;
  logic [CPUS-1:0] darb_req, iarb_req;
  logic [CPUS-1:0] d_gnt, i_gnt;
  logic            d_vld, i_vld;
  logic            darb_adv, iarb_adv;
  logic            d_win, i_win;

  // a write wins over a read on the same dcache port; both are one request
  assign dreq = dREN | dWEN;

  // every port sees the single capture register
  assign iload = {CPUS{load_q}};
  assign dload = {CPUS{load_q}};

  // one-hot of the granted core, used to steer the pointer update in DONE
  always_comb begin
    done_oh = '0;
    done_oh[grant.cpu] = 1'b1;
  end

  // in DONE the arbiters see only the finished winner so advance skips past it
  assign darb_adv = (state == BC_DONE) &&  grant.is_data;
  assign iarb_adv = (state == BC_DONE) && !grant.is_data;
  assign darb_req = darb_adv ? done_oh : dreq;
  assign iarb_req = iarb_adv ? done_oh : iREN;

  rr_arbiter #(.N(CPUS)) u_darb (
    .CLK     (CLK),
    .nRST    (nRST),
    .req     (darb_req),
    .advance (darb_adv),
    .gnt     (d_gnt),
    .valid   (d_vld)
  );

  rr_arbiter #(.N(CPUS)) u_iarb (
    .CLK     (CLK),
    .nRST    (nRST),
    .req     (iarb_req),
    .advance (iarb_adv),
    .gnt     (i_gnt),
    .valid   (i_vld)
  );

  // one-hot grant to core index
  always_comb begin
    d_win = 1'b0;
    i_win = 1'b0;
    for (int c = 0; c < CPUS; c++) begin
      if (d_gnt[c]) d_win = 1'(c);
      if (i_gnt[c]) i_win = 1'(c);
    end
  end

  // priority: burst lock holder, then any dcache, then any icache
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    if (burst_cnt && dreq[lock]) begin
      sel_vld     = 1'b1;
      sel.cpu     = lock;
      sel.is_data = 1'b1;
    end else if (d_vld) begin
      sel_vld     = 1'b1;
      sel.cpu     = d_win;
      sel.is_data = 1'b1;
    end else if (i_vld) begin
      sel_vld     = 1'b1;
      sel.cpu     = i_win;
    end
    sel.is_write = sel.is_data & dWEN[sel.cpu];
    sel_addr     = sel.is_data ? daddr[sel.cpu] : iaddr[sel.cpu];
  end

  // IDLE -> BUSY -> DONE -> IDLE with all outputs registered
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= BC_IDLE;
      grant     <= '0;
      iwait     <= '1;
      dwait     <= '1;
      load_q    <= '0;
      ramREN    <= 1'b0;
      ramWEN    <= 1'b0;
      ramaddr   <= '0;
      ramstore  <= '0;
      timer     <= '0;
      lock      <= 1'b0;
      burst_cnt <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        BC_IDLE: begin
          timer <= '0;
          // burst abandoned: the locked dcache no longer wants its second word
          if (burst_cnt && !dreq[lock]) begin
            burst_cnt <= 1'b0;
            lock      <= 1'b0;
          end
          if (sel_vld) begin
            grant   <= sel;
            ramaddr <= sel_addr;
            if (sel.is_write)
              ramstore <= dstore[sel.cpu];
            ramREN  <= ~sel.is_write;
            ramWEN  <= sel.is_write;
            state   <= BC_BUSY;
          end
        end

        BC_BUSY: begin
          timer <= timer + 1'b1;
          if (ramstate == ACCESS) begin
            if (!grant.is_write)
              load_q <= ramload;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= BC_DONE;
            if (grant.is_data) dwait[grant.cpu] <= 1'b0;
            else               iwait[grant.cpu] <= 1'b0;
          end else if (ramstate == ERROR || timer == TW'(TIMEOUT)) begin
            load_q <= ERR_DATA;
            err    <= 1'b1;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= BC_DONE;
            if (grant.is_data) dwait[grant.cpu] <= 1'b0;
            else               iwait[grant.cpu] <= 1'b0;
          end
        end

        BC_DONE: begin
          iwait <= '1;
          dwait <= '1;
          timer <= '0;
          state <= BC_IDLE;
          // first data word takes the lock, second word releases it
          if (grant.is_data) begin
            if (!burst_cnt) begin
              lock      <= grant.cpu;
              burst_cnt <= 1'b1;
            end else begin
              lock      <= 1'b0;
              burst_cnt <= 1'b0;
            end
          end
        end

        default: state <= BC_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_controller.sv
// Directed bench for bus_controller: single-word vector table plus
// sequences for arbitration order, burst atomicity, mid-transaction reset and timeout.
module tb_bus_controller;
  import cpu_types_pkg::*;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN, dREN, dWEN, iwait, dwait;
  logic [1:0][31:0] iaddr, daddr, dstore, iload, dload;
  logic             ramREN, ramWEN, err;
  logic [31:0]      ramaddr, ramstore, ramload;
  ramstate_t        ramstate;

  int total = 0;
  int bad   = 0;

  logic [31:0] order_q[$];
  logic [7:0]  done_q[$];
  int          dleft[2];

  localparam logic [31:0] RKEY = 32'hC0DE0000;

  typedef struct {
    logic        is_data;
    logic        is_write;
    int          cpu;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] rdata;
    int          stall;
    ramstate_t   last;
    logic [31:0] exp_load;
    int          exp_en;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  bus_controller #(.CPUS(2), .TIMEOUT(255), .ERR_DATA(32'hBAD1BAD1)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] qaddr(input int i);
    return (i < order_q.size()) ? order_q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [7:0] qdone(input int i);
    return (i < done_q.size()) ? done_q[i] : 8'hFF;
  endfunction

  // one isolated word: drive the request, play RAM, check the done cycle
  task automatic run_txn(input vec_t v, input int id);
    int         en;
    int         badbus;
    bit         done;
    logic       own;
    logic [3:0] others;
    en = 0; badbus = 0; done = 1'b0;
    @(negedge CLK);
    if (v.is_data) begin
      dREN[v.cpu]   = !v.is_write;
      dWEN[v.cpu]   = v.is_write;
      daddr[v.cpu]  = v.addr;
      dstore[v.cpu] = v.store;
    end else begin
      iREN[v.cpu]  = 1'b1;
      iaddr[v.cpu] = v.addr;
    end
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge CLK);
      if (ramREN || ramWEN) begin
        if (ramaddr !== v.addr || ramWEN !== v.is_write || ramREN !== !v.is_write ||
            (v.is_write && ramstore !== v.store))
          badbus++;
        ramstate = (en < v.stall) ? BUSY : v.last;
        ramload  = v.rdata;
        en++;
      end else begin
        ramstate = FREE;
      end
      own = v.is_data ? dwait[v.cpu] : iwait[v.cpu];
      if (!own) begin
        done = 1'b1;
        chk($sformatf("v%0d load", id), v.is_data ? dload[v.cpu] : iload[v.cpu], v.exp_load);
        chk($sformatf("v%0d enable_cycles", id), 32'(en), 32'(v.exp_en));
        chk($sformatf("v%0d err", id), 32'(err), 32'(v.exp_err));
        chk($sformatf("v%0d bus_signals", id), 32'(badbus), 32'd0);
        others = {dwait, iwait};
        others[(v.is_data ? 2 : 0) + v.cpu] = 1'b1;
        chk($sformatf("v%0d other_waits", id), 32'(others), 32'hF);
        dREN = '0; dWEN = '0; iREN = '0;
      end
    end
    if (!done) begin
      chk($sformatf("v%0d no_done", id), 32'd0, 32'd1);
      dREN = '0; dWEN = '0; iREN = '0;
    end
    @(negedge CLK);
    ramstate = FREE;
    chk($sformatf("v%0d wait_released", id), 32'({dwait, iwait}), 32'hF);
  endtask

  // multi-requester run: plays RAM and caches (dcache bursts of dleft words)
  task automatic serve_all(input int stall, input string nm);
    int en, multi, lows;
    bit fin;
    en = 0; multi = 0; fin = 1'b0;
    order_q.delete();
    done_q.delete();
    for (int k = 0; k < 300 && !fin; k++) begin
      @(negedge CLK);
      lows = 0;
      for (int c = 0; c < 2; c++) begin
        if (!iwait[c]) lows++;
        if (!dwait[c]) lows++;
      end
      if (lows > 1) multi++;
      if (ramREN || ramWEN) begin
        if (en == 0) order_q.push_back(ramaddr);
        ramstate = (en < stall) ? BUSY : ACCESS;
        ramload  = ramaddr ^ RKEY;
        en++;
      end else begin
        en = 0;
        ramstate = FREE;
      end
      for (int c = 0; c < 2; c++) begin
        if (dREN[c] && !dwait[c]) begin
          chk($sformatf("%s d%0d load", nm, c), dload[c], qaddr(order_q.size()-1) ^ RKEY);
          done_q.push_back(8'hD0 + 8'(c));
          dleft[c]--;
          daddr[c] = daddr[c] + 32'd4;
          if (dleft[c] == 0) dREN[c] = 1'b0;
        end
        if (iREN[c] && !iwait[c]) begin
          chk($sformatf("%s i%0d load", nm, c), iload[c], qaddr(order_q.size()-1) ^ RKEY);
          done_q.push_back(8'hA0 + 8'(c));
          iREN[c] = 1'b0;
        end
      end
      fin = (iREN == 2'b00) && (dREN == 2'b00) && !ramREN && !ramWEN &&
            ({iwait, dwait} == 4'hF);
    end
    if (!fin) begin
      chk({nm, " not_finished"}, 32'd0, 32'd1);
      iREN = '0; dREN = '0;
    end
    chk({nm, " one_done_at_a_time"}, 32'(multi), 32'd0);
  endtask

  initial begin
    //           data  wr    cpu addr          store         rdata         stall last    exp_load      en   err
    vecs[0] = '{1'b0, 1'b0, 0, 32'h0000_0040, 32'h0,        32'h1111_2222, 2, ACCESS, 32'h1111_2222, 3,   1'b0};
    vecs[1] = '{1'b0, 1'b0, 1, 32'h0000_0044, 32'h0,        32'hA5A5_5A5A, 0, ACCESS, 32'hA5A5_5A5A, 1,   1'b0};
    vecs[2] = '{1'b1, 1'b0, 1, 32'h0000_0300, 32'h0,        32'h1234_5678, 1, ACCESS, 32'h1234_5678, 2,   1'b0};
    vecs[3] = '{1'b1, 1'b1, 0, 32'h0000_0080, 32'hDEADBEEF, 32'hFFFF_FFFF, 3, ACCESS, 32'h1234_5678, 4,   1'b0};
    vecs[4] = '{1'b1, 1'b0, 0, 32'h0000_0090, 32'h0,        32'h5555_5555, 1, ERROR,  32'hBAD1_BAD1, 2,   1'b1};
    vecs[5] = '{1'b0, 1'b0, 1, 32'h0000_0050, 32'h0,        32'h0F0F_0F0F, 0, ACCESS, 32'h0F0F_0F0F, 1,   1'b1};
    vecs[6] = '{1'b1, 1'b1, 1, 32'h0000_0084, 32'hCAFEF00D, 32'h0,        0, ACCESS, 32'h0F0F_0F0F, 1,   1'b1};

    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
    dleft[0] = 0; dleft[1] = 0;
    repeat (2) @(negedge CLK);
    chk("rst iwait",    32'(iwait),   32'h3);
    chk("rst dwait",    32'(dwait),   32'h3);
    chk("rst ramREN",   32'(ramREN),  32'h0);
    chk("rst ramWEN",   32'(ramWEN),  32'h0);
    chk("rst ramaddr",  ramaddr,      32'h0);
    chk("rst ramstore", ramstore,     32'h0);
    chk("rst iload",    iload[0],     32'h0);
    chk("rst dload",    dload[1],     32'h0);
    chk("rst err",      32'(err),     32'h0);
    nRST = 1'b1;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // reset while the RAM is stalling an icache read
    @(negedge CLK);
    iREN[0] = 1'b1; iaddr[0] = 32'h40; ramstate = BUSY;
    for (int k = 0; k < 10 && !ramREN; k++) @(negedge CLK);
    chk("midrst started", 32'(ramREN), 32'h1);
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    chk("midrst ramREN", 32'(ramREN), 32'h0);
    chk("midrst waits",  32'({iwait, dwait}), 32'hF);
    chk("midrst err",    32'(err), 32'h0);
    chk("midrst load",   iload[0], 32'h0);
    chk("midrst ramaddr", ramaddr, 32'h0);
    nRST = 1'b1; iREN = '0; ramstate = FREE;
    @(negedge CLK);

    // both dcaches fill 2-word blocks: core0's block completes before core1 starts
    dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h200;
    dleft[0] = 2; dleft[1] = 2;
    serve_all(1, "burst");
    chk("burst n",  32'(order_q.size()), 32'd4);
    chk("burst w0", qaddr(0), 32'h100);
    chk("burst w1", qaddr(1), 32'h104);
    chk("burst w2", qaddr(2), 32'h200);
    chk("burst w3", qaddr(3), 32'h204);

    // icache0 vs dcache1 at the same time: dcache first
    @(negedge CLK);
    iREN[0] = 1'b1; iaddr[0] = 32'h40;
    dREN[1] = 1'b1; daddr[1] = 32'h500; dleft[1] = 1;
    serve_all(2, "mix");
    chk("mix first",   qaddr(0), 32'h500);
    chk("mix second",  qaddr(1), 32'h40);
    chk("mix done0",   32'(qdone(0)), 32'hD1);
    chk("mix done1",   32'(qdone(1)), 32'hA0);

    // RAM never answers: forced completion with the error word, then normal service
    run_txn('{1'b1, 1'b0, 0, 32'h600, 32'h0, 32'h0, 1000, BUSY, 32'hBAD1_BAD1, 256, 1'b1}, 100);
    run_txn('{1'b0, 1'b0, 1, 32'h070, 32'h0, 32'h7777_0001, 0, ACCESS, 32'h7777_0001, 1, 1'b1}, 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
